// File: rtl/shift_pipe_pkg.sv
// Shared types and helpers for the shift_pipe delay line.
// Optional stage parity storage: SHIFT_PIPE_PARITY_EN.
package shift_pipe_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'b00,
    SHIFT  = 2'b01,
    ROTATE = 2'b10,
    LOAD   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'b00,
    SEL_PREV = 2'b01,
    SEL_LOAD = 2'b10
  } sel_e;

  localparam int PAR_MAXW = 64;

  // Even parity: stored bit makes word+parity hold an even count of ones.
  function automatic logic f_parity(input logic [PAR_MAXW-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// One delay-line stage: word, valid flag and optional parity bit.
// Parity storage present only with SHIFT_PIPE_PARITY_EN.
module shift_pipe_stage
  import shift_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk160_i,
  input  logic             rstn_i,
  input  logic             clear_i,
  input  sel_e             sel_i,
  input  logic [WIDTH-1:0] prev_data_i,
  input  logic             prev_vld_i,
  input  logic [WIDTH-1:0] load_data_i,
`ifdef SHIFT_PIPE_PARITY_EN
  input  logic             prev_par_i,
  output logic             par_o,
  output logic             par_bad_o,
`endif
  output logic [WIDTH-1:0] data_o,
  output logic             vld_o
);

  logic [WIDTH-1:0] r_data;
  logic             r_vld;
  logic [WIDTH-1:0] w_data_nxt;
  logic             w_vld_nxt;

  always_comb begin
    w_data_nxt = r_data;
    w_vld_nxt  = r_vld;
    unique case (1'b1)
      sel_i == SEL_PREV: begin
        w_data_nxt = prev_data_i;
        w_vld_nxt  = prev_vld_i;
      end
      sel_i == SEL_LOAD: begin
        w_data_nxt = load_data_i;
        w_vld_nxt  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk160_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_data <= '0;
      r_vld  <= 1'b0;
    end else if (clear_i) begin
      r_data <= '0;
      r_vld  <= 1'b0;
    end else begin
      r_data <= w_data_nxt;
      r_vld  <= w_vld_nxt;
    end
  end

  assign data_o = r_data;
  assign vld_o  = r_vld;

`ifdef SHIFT_PIPE_PARITY_EN
  logic r_par;
  logic w_par_nxt;

  always_comb begin
    w_par_nxt = r_par;
    unique case (1'b1)
      sel_i == SEL_PREV: w_par_nxt = prev_par_i;
      sel_i == SEL_LOAD: w_par_nxt = f_parity(PAR_MAXW'(load_data_i));
      default: ;
    endcase
  end

  always_ff @(posedge clk160_i or negedge rstn_i) begin
    if (!rstn_i)      r_par <= 1'b0;
    else if (clear_i) r_par <= 1'b0;
    else              r_par <= w_par_nxt;
  end

  assign par_o     = r_par;
  assign par_bad_o = r_vld & (f_parity(PAR_MAXW'(r_data)) != r_par);
`endif

endmodule

// File: rtl/shift_pipe_param.sv
// Parametrised WIDTH x DEPTH shift/rotate/load delay line with fill count.
// Optional stage parity checking: SHIFT_PIPE_PARITY_EN.
module shift_pipe_param
  import shift_pipe_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int TAPW  = $clog2(DEPTH),
  localparam int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic                   clk160_i,
  input  logic                   rstn_i,
  input  logic                   clear_i,
  input  logic [1:0]             mode_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   valid_i,
  input  logic [WIDTH*DEPTH-1:0] load_i,
  input  logic [TAPW-1:0]        tap_sel_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   valid_o,
  output logic [WIDTH-1:0]       tap_o,
  output logic [WIDTH*DEPTH-1:0] par_o,
  output logic [CNTW-1:0]        fill_o,
  output logic                   full_o,
`ifdef SHIFT_PIPE_PARITY_EN
  output logic                   parity_err_o,
`endif
  output logic                   empty_o
);

  mode_e                  w_mode;
  sel_e                   w_sel;
  logic [WIDTH*DEPTH-1:0] w_words;
  logic [DEPTH-1:0]       w_vld;
  logic [CNTW-1:0]        r_fill;
  logic [WIDTH-1:0]       w_tap;

  assign w_mode = mode_e'(mode_i);

  always_comb begin
    w_sel = SEL_HOLD;
    unique case (1'b1)
      w_mode == SHIFT,
      w_mode == ROTATE: w_sel = SEL_PREV;
      w_mode == LOAD:   w_sel = SEL_LOAD;
      default: ;
    endcase
  end

`ifdef SHIFT_PIPE_PARITY_EN
  logic [DEPTH-1:0] w_par;
  logic [DEPTH-1:0] w_par_bad;
  logic             r_par_err;
`endif

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] w_prev_d;
    logic             w_prev_v;
`ifdef SHIFT_PIPE_PARITY_EN
    logic             w_prev_p;
`endif
    if (k == 0) begin : g_head
      // Stage 0 takes the serial input, or the last stage when rotating.
      assign w_prev_d = (w_mode == ROTATE) ?
        w_words[(DEPTH-1)*WIDTH +: WIDTH] : data_i;
      assign w_prev_v = (w_mode == ROTATE) ?
        w_vld[DEPTH-1] : valid_i;
`ifdef SHIFT_PIPE_PARITY_EN
      assign w_prev_p = (w_mode == ROTATE) ?
        w_par[DEPTH-1] : f_parity(PAR_MAXW'(data_i));
`endif
    end else begin : g_body
      assign w_prev_d = w_words[(k-1)*WIDTH +: WIDTH];
      assign w_prev_v = w_vld[k-1];
`ifdef SHIFT_PIPE_PARITY_EN
      assign w_prev_p = w_par[k-1];
`endif
    end

    shift_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk160_i   (clk160_i),
      .rstn_i     (rstn_i),
      .clear_i    (clear_i),
      .sel_i      (w_sel),
      .prev_data_i(w_prev_d),
      .prev_vld_i (w_prev_v),
      .load_data_i(load_i[k*WIDTH +: WIDTH]),
`ifdef SHIFT_PIPE_PARITY_EN
      .prev_par_i (w_prev_p),
      .par_o      (w_par[k]),
      .par_bad_o  (w_par_bad[k]),
`endif
      .data_o     (w_words[k*WIDTH +: WIDTH]),
      .vld_o      (w_vld[k])
    );
  end

  always_ff @(posedge clk160_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_fill <= '0;
    end else if (clear_i) begin
      r_fill <= '0;
    end else begin
      unique case (1'b1)
        w_mode == SHIFT:
          r_fill <= r_fill + CNTW'(valid_i)
                  - CNTW'(w_vld[DEPTH-1]);
        w_mode == LOAD:
          r_fill <= CNTW'(DEPTH);
        default: ;
      endcase
    end
  end

  // Out-of-range selects (non-power-of-two DEPTH) read as zero.
  always_comb begin
    w_tap = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (tap_sel_i == TAPW'(k))
        w_tap = w_words[k*WIDTH +: WIDTH];
    end
  end

`ifdef SHIFT_PIPE_PARITY_EN
  always_ff @(posedge clk160_i or negedge rstn_i) begin
    if (!rstn_i)         r_par_err <= 1'b0;
    else if (clear_i)    r_par_err <= 1'b0;
    else if (|w_par_bad) r_par_err <= 1'b1;
  end

  assign parity_err_o = r_par_err;
`endif

  assign data_o  = w_words[(DEPTH-1)*WIDTH +: WIDTH];
  assign valid_o = w_vld[DEPTH-1];
  assign tap_o   = w_tap;
  assign par_o   = w_words;
  assign fill_o  = r_fill;
  assign full_o  = (r_fill == CNTW'(DEPTH));
  assign empty_o = (r_fill == '0);

endmodule

// File: tb/tb_shift_pipe_param.sv
// Scoreboard bench for shift_pipe_param (WIDTH=8, DEPTH=4).
// Parity section compiled only with SHIFT_PIPE_PARITY_EN.
module tb_shift_pipe_param;
  import shift_pipe_pkg::*;

  localparam int W = 8;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          clr;
  logic [1:0]    mode;
  logic [W-1:0]  din;
  logic          vin;
  logic [W*D-1:0] ld;
  logic [1:0]    tsel;
  logic [W-1:0]  dout;
  logic          vout;
  logic [W-1:0]  tap;
  logic [W*D-1:0] par;
  logic [2:0]    fill;
  logic          full;
  logic          empty;
`ifdef SHIFT_PIPE_PARITY_EN
  logic          perr;
`endif

  always #5 clk = ~clk;

  shift_pipe_param #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .clk160_i (clk),
    .rstn_i   (rstn),
    .clear_i  (clr),
    .mode_i   (mode),
    .data_i   (din),
    .valid_i  (vin),
    .load_i   (ld),
    .tap_sel_i(tsel),
    .data_o   (dout),
    .valid_o  (vout),
    .tap_o    (tap),
    .par_o    (par),
    .fill_o   (fill),
    .full_o   (full),
`ifdef SHIFT_PIPE_PARITY_EN
    .parity_err_o(perr),
`endif
    .empty_o  (empty)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [W*D-1:0] par;
    logic [D-1:0]   vld;
    logic [2:0]     fill;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_s[D];
  logic [D-1:0] m_v;

  function automatic logic [W*D-1:0] m_par();
    logic [W*D-1:0] p;
    for (int k = 0; k < D; k++) p[k*W +: W] = m_s[k];
    return p;
  endfunction

  task automatic m_clear();
    for (int k = 0; k < D; k++) m_s[k] = '0;
    m_v = '0;
  endtask

  task automatic cyc(input logic [1:0] md, input logic [W-1:0] d,
                     input logic v, input logic [W*D-1:0] l,
                     input logic c);
    exp_t         e;
    logic [W-1:0] t;
    logic         tv;
    @(negedge clk);
    mode = md; din = d; vin = v; ld = l; clr = c;
    if (c) m_clear();
    else begin
      t  = m_s[D-1];
      tv = m_v[D-1];
      case (md)
        2'b01, 2'b10: begin
          for (int k = D-1; k > 0; k--) begin
            m_s[k] = m_s[k-1];
            m_v[k] = m_v[k-1];
          end
          m_s[0] = (md == 2'b01) ? d : t;
          m_v[0] = (md == 2'b01) ? v : tv;
        end
        2'b11: begin
          for (int k = 0; k < D; k++) m_s[k] = l[k*W +: W];
          m_v = '1;
        end
        default: ;
      endcase
    end
    e.par  = m_par();
    e.vld  = m_v;
    e.fill = 3'($countones(m_v));
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
    else begin
      e = sb.pop_front();
      chk("par_o", par, e.par);
      chk("data_o", dout, e.par[(D-1)*W +: W]);
      chk("valid_o", vout, e.vld[D-1]);
      chk("fill_o", fill, e.fill);
      chk("full_o", full, e.fill == 3'(D));
      chk("empty_o", empty, e.fill == 3'd0);
      chk("tap_o", tap, m_s[tsel]);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, dout, 0);
    chk({tag, "_valid"}, vout, 0);
    chk({tag, "_tap"}, tap, 0);
    chk({tag, "_par"}, par, 0);
    chk({tag, "_fill"}, fill, 0);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_empty"}, empty, 1);
  endtask

  initial begin
    rstn = 1'b0; clr = 1'b0; mode = 2'b00; din = '0;
    vin = 1'b0; ld = '0; tsel = 2'd0;
    m_clear();
    #2;
    chk_zero("rst");
    @(negedge clk);
    rstn = 1'b1;

    // fill and latency
    cyc(SHIFT, 8'h11, 1'b1, '0, 1'b0);
    cyc(SHIFT, 8'h22, 1'b1, '0, 1'b0);
    cyc(SHIFT, 8'h33, 1'b1, '0, 1'b0);
    cyc(SHIFT, 8'h44, 1'b1, '0, 1'b0);
    chk("fill_par", par, 32'h11223344);
    chk("fill_data", dout, 8'h11);
    chk("fill_full", full, 1'b1);

    // drain with invalid words entering
    for (int i = 0; i < 4; i++)
      cyc(SHIFT, 8'hE0 + 8'(i), 1'b0, '0, 1'b0);
    chk("drain_empty", empty, 1'b1);
    chk("drain_retained", dout, 8'hE0);

    // load, rotate, hold, tap
    cyc(LOAD, 8'h00, 1'b0, 32'hA1B2C3D4, 1'b0);
    cyc(ROTATE, 8'hFF, 1'b0, '0, 1'b0);
    chk("rot_par", par, 32'hB2C3D4A1);
    chk("rot_fill", fill, 3'd4);
    tsel = 2'd2;
    for (int i = 0; i < 3; i++) cyc(HOLD, 8'h5, 1'b1, '0, 1'b0);
    chk("hold_par", par, 32'hB2C3D4A1);
    chk("tap2", tap, 8'hC3);

    // clear wins over load
    cyc(LOAD, 8'h00, 1'b0, 32'hFFFFFFFF, 1'b1);
    chk("clr_par", par, 0);
    chk("clr_fill", fill, 0);

    // latency with holds in between
    cyc(SHIFT, 8'h5A, 1'b1, '0, 1'b0);
    cyc(HOLD, 8'h00, 1'b0, '0, 1'b0);
    cyc(HOLD, 8'h00, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(SHIFT, 8'h00, 1'b0, '0, 1'b0);
    chk("lat_data", dout, 8'h5A);
    chk("lat_valid", vout, 1'b1);

    // random traffic
    for (int i = 0; i < 60; i++) begin
      tsel = 2'($urandom_range(0, 3));
      cyc(2'($urandom_range(0, 3)), 8'($urandom),
          1'($urandom), 32'($urandom), ($urandom_range(0, 15) == 0));
    end

    // asynchronous reset mid-operation
    cyc(LOAD, 8'h00, 1'b0, 32'h01020304, 1'b0);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk_zero("arst");
    m_clear();
    @(negedge clk);
    rstn = 1'b1;
    mode = HOLD;

`ifdef SHIFT_PIPE_PARITY_EN
    cyc(LOAD, 8'h00, 1'b0, 32'h12345678, 1'b0);
    chk("perr_idle", perr, 1'b0);
    @(negedge clk);
    mode = HOLD;
    force dut.g_stage[1].u_stage.r_data = 8'h56 ^ 8'h01;
    @(posedge clk);
    #1;
    release dut.g_stage[1].u_stage.r_data;
    chk("perr_set", perr, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("perr_sticky", perr, 1'b1);
    end
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    chk("perr_clr", perr, 1'b0);
    @(negedge clk);
    clr = 1'b0;
    m_clear();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
